mem_access_stage: RTL
=====================

// Module: mem_access_stage
// PURPOSE
//  Pipeline stage directly downstream of EXE. Registers one EXE result and performs the data-memory
//  access over a req/ack SRAM port: loads, stores, and unaligned LWL/LWR/SWL/SWR as a single access.
//  Aligns and extends load data, produces the register-write value for WB, and flags address errors.
//  Exposes its write destination for hazard detection; supports flush with a drain of any in-flight access.
// PARAMETERS
//  CHECK_ALIGN  1  1: misaligned LW/SW/LH/LHU/SH raises adel/ades and skips the access; 0: no check
// PORTS
//  clk           in   1   clock; all state updates on posedge
//  resetn        in   1   asynchronous active-low reset
//  exe_valid     in   1   EXE presents a finished instruction (EXE_over)
//  mem_allowin   out  1   stage can capture this cycle
//  exe_load      in   1   load instruction
//  exe_store     in   1   store instruction
//  exe_size      in   2   00 byte, 01 half, 10 word (ignored when ls_left/ls_right)
//  exe_unsign    in   1   zero-extend LB/LH
//  exe_ls_left   in   1   LWL/SWL
//  exe_ls_right  in   1   LWR/SWR
//  exe_result    in   32  ALU result / effective address
//  exe_rt        in   32  rt value: store data and LWL/LWR merge source
//  exe_wen       in   1   register write enable
//  exe_wdest     in   5   destination register
//  exe_pc        in   32  PC of the instruction
//  flush         in   1   discard stage contents (exception/eret)
//  dm_req        out  1   data-memory request; held until dm_ack
//  dm_wr         out  1   1 store, 0 load
//  dm_addr       out  32  word address {addr[31:2],2'b00}
//  dm_wstrb      out  4   byte write strobes (0 for loads)
//  dm_wdata      out  32  shifted store data
//  dm_ack        in   1   access complete; dm_rdata valid this cycle for loads
//  dm_rdata      in   32  read word
//  wb_allowin    in   1   WB can accept
//  mem_to_wb_valid out 1  result valid to WB
//  mem_wen       out  1   write enable to WB (0 on address error)
//  mem_wdest     out  5   destination; 0 when stage is empty (hazard check)
//  mem_wdata     out  32  load result or pass-through exe_result
//  mem_pc        out  32  PC
//  mem_adel      out  1   load address error
//  mem_ades      out  1   store address error
//  mem_badvaddr  out  32  faulting byte address
// BEHAVIOUR
//  Reset: state EMPTY; dm_req=0, mem_to_wb_valid=0, mem_wen=0, mem_wdest=0, mem_adel=mem_ades=0, other outputs 0.
//  States: EMPTY, ISSUE, DONE, DRAIN. mem_allowin = (EMPTY) | (DONE & wb_allowin); 0 in ISSUE/DRAIN.
//  Capture when exe_valid & mem_allowin & !flush: memory op -> ISSUE (dm_req high next cycle); non-memory op
//   or address error -> DONE with wdata=exe_result. Captured fields stay stable until the next capture.
//  ISSUE: dm_req held with stable addr/wr/wstrb/wdata; on dm_ack load data is aligned and registered -> DONE.
//   Minimum memory latency 2 cycles (capture, ack); non-memory latency 1 cycle.
//  DONE: mem_to_wb_valid=1; leaves on wb_allowin (back-to-back capture allowed same cycle), else holds.
//  Alignment (a=addr[1:0]): misaligned = (word & a!=0) | (half & a[0]); never for left/right or byte.
//  Store strobes: SB 0001<<a; SH a[1]?1100:0011; SW 1111; SWL a0..3 = 0001,0011,0111,1111;
//   SWR a0..3 = 1111,1110,1100,1000. wdata: SB {4{rt[7:0]}}, SH {2{rt[15:0]}}, SW rt,
//   SWL rt>>(8*(3-a)), SWR rt<<(8*a).
//  Loads: byte/half selected by a, sign- or zero-extended per exe_unsign; LWL = (rdata<<8*(3-a)) | (rt & ~(32'hFFFFFFFF<<8*(3-a)));
//   LWR = (rdata>>8*a) | (rt & ~(32'hFFFFFFFF>>8*a)).
//  Flush: EMPTY/DONE -> EMPTY next cycle, valid drops. ISSUE -> DRAIN: dm_req stays high until dm_ack, data
//   discarded, then EMPTY. Flush same cycle as dm_ack in ISSUE -> EMPTY. No capture while flush=1.
//  Reset asserted mid-access aborts immediately; the memory side is reset by the same resetn.
// STRUCTURE
//  mem_stage_pkg: state encoding, size codes (SZ_BYTE/SZ_HALF/SZ_WORD), strobe tables.
//  Sub-module mem_load_align: combinational rdata+rt+a+size+flags -> 32-bit load result.
//  Store strobe/data generation and FSM live in this module.
// TESTING
//  LB addr 0x103, rdata 0x80AABBCC, unsign=0 -> mem_wdata 0xFFFFFF80; LBU -> 0x00000080.
//  SWR addr 0x201, rt 0x11223344 -> dm_wstrb 1110, dm_wdata 0x22334400, dm_addr 0x200.
//  LWL addr 0x301, rt 0xAABBCCDD, rdata 0x11223344 -> mem_wdata 0x3344CCDD; LWR same -> 0xAA112233.
//  LW addr 0x402 -> no dm_req, mem_adel=1, mem_badvaddr 0x402, mem_wen=0, valid next cycle.
//  ack delayed 5 cycles, wb_allowin=0 two further cycles -> dm_req stable 5 cycles, mem_allowin=0 throughout, one WB transfer.
//  flush during ISSUE, ack 3 cycles later -> DRAIN, no mem_to_wb_valid, mem_allowin=1 cycle after ack.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the data-memory access stage:
// FSM states, access size codes and unaligned store strobe tables.
package mem_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2,
    ST_DRAIN = 2'd3
  } mem_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  function automatic logic [3:0] swl_strb(input logic [1:0] a);
    logic [3:0] s;
    unique case (a)
      2'd0: s = 4'b0001;
      2'd1: s = 4'b0011;
      2'd2: s = 4'b0111;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] swr_strb(input logic [1:0] a);
    logic [3:0] s;
    unique case (a)
      2'd0: s = 4'b1111;
      2'd1: s = 4'b1110;
      2'd2: s = 4'b1100;
      default: s = 4'b1000;
    endcase
    return s;
  endfunction

  // Left/right and byte accesses can never be misaligned.
  function automatic logic misaligned(
    input logic [1:0] size,
    input logic [1:0] a,
    input logic       lr
  );
    return !lr && (((size == SZ_WORD) && (a != 2'b00)) ||
                   ((size == SZ_HALF) && a[0]));
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data alignment: byte/half select with extension,
// and LWL/LWR merge of the read word into the old rt value.
module mem_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [31:0] rt_i,
  input  logic [1:0]  a_i,
  input  logic [1:0]  size_i,
  input  logic        unsign_i,
  input  logic        left_i,
  input  logic        right_i,
  output logic [31:0] result_o
);

  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic [4:0]  sh_l;
  logic [4:0]  sh_r;
  logic [31:0] rsh;
  logic [15:0] half_v;

  always_comb begin
    sh_l   = {~a_i, 3'b000};
    sh_r   = {a_i, 3'b000};
    rsh    = rdata_i >> sh_r;
    half_v = a_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    result_o = rdata_i;
    if (left_i) begin
      result_o = (rdata_i << sh_l) | (rt_i & ~(ONES << sh_l));
    end else if (right_i) begin
      result_o = rsh | (rt_i & ~(ONES >> sh_r));
    end else if (size_i == SZ_BYTE) begin
      result_o = {{24{~unsign_i & rsh[7]}}, rsh[7:0]};
    end else if (size_i == SZ_HALF) begin
      result_o = {{16{~unsign_i & half_v[15]}}, half_v};
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: holds one EXE result, runs the req/ack
// data-memory access and hands the write-back value to WB.
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int CHECK_ALIGN = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        exe_valid,
  output logic        mem_allowin,
  input  logic        exe_load,
  input  logic        exe_store,
  input  logic [1:0]  exe_size,
  input  logic        exe_unsign,
  input  logic        exe_ls_left,
  input  logic        exe_ls_right,
  input  logic [31:0] exe_result,
  input  logic [31:0] exe_rt,
  input  logic        exe_wen,
  input  logic [4:0]  exe_wdest,
  input  logic [31:0] exe_pc,
  input  logic        flush,
  output logic        dm_req,
  output logic        dm_wr,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_ack,
  input  logic [31:0] dm_rdata,
  input  logic        wb_allowin,
  output logic        mem_to_wb_valid,
  output logic        mem_wen,
  output logic [4:0]  mem_wdest,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_pc,
  output logic        mem_adel,
  output logic        mem_ades,
  output logic [31:0] mem_badvaddr
);

  mem_state_e  state_q, state_d;
  logic        load_q, store_q, unsign_q;
  logic        left_q, right_q, wen_q;
  logic        adel_q, ades_q;
  logic [1:0]  size_q;
  logic [4:0]  wdest_q;
  logic [31:0] addr_q, rt_q, pc_q, wdata_q;

  logic        mis, capture, busy;
  mem_state_e  cap_state;
  logic [1:0]  a;
  logic [3:0]  st_strb;
  logic [31:0] st_data, ld_result;

  assign mis = (CHECK_ALIGN != 0) &&
               misaligned(exe_size, exe_result[1:0],
                          exe_ls_left | exe_ls_right);
  assign mem_allowin = (state_q == ST_EMPTY) ||
                       ((state_q == ST_DONE) && wb_allowin);
  assign capture   = exe_valid && mem_allowin && !flush;
  assign cap_state = ((exe_load || exe_store) && !mis) ?
                     ST_ISSUE : ST_DONE;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_EMPTY: if (capture) state_d = cap_state;
      ST_ISSUE: begin
        if (flush)       state_d = dm_ack ? ST_EMPTY : ST_DRAIN;
        else if (dm_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (flush)           state_d = ST_EMPTY;
        else if (wb_allowin) state_d = capture ? cap_state : ST_EMPTY;
      end
      ST_DRAIN: if (dm_ack) state_d = ST_EMPTY;
      default: state_d = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ST_EMPTY;
      load_q   <= 1'b0;
      store_q  <= 1'b0;
      unsign_q <= 1'b0;
      left_q   <= 1'b0;
      right_q  <= 1'b0;
      wen_q    <= 1'b0;
      adel_q   <= 1'b0;
      ades_q   <= 1'b0;
      size_q   <= SZ_BYTE;
      wdest_q  <= 5'd0;
      addr_q   <= 32'd0;
      rt_q     <= 32'd0;
      pc_q     <= 32'd0;
      wdata_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (capture) begin
        load_q   <= exe_load;
        store_q  <= exe_store;
        unsign_q <= exe_unsign;
        left_q   <= exe_ls_left;
        right_q  <= exe_ls_right;
        wen_q    <= exe_wen;
        adel_q   <= exe_load & mis;
        ades_q   <= exe_store & mis;
        size_q   <= exe_size;
        wdest_q  <= exe_wdest;
        addr_q   <= exe_result;
        rt_q     <= exe_rt;
        pc_q     <= exe_pc;
        wdata_q  <= exe_result;
      end else if (state_q == ST_ISSUE && dm_ack &&
                   !flush && load_q) begin
        wdata_q <= ld_result;
      end
    end
  end

  assign a = addr_q[1:0];

  always_comb begin
    st_strb = 4'b1111;
    st_data = rt_q;
    if (left_q) begin
      st_strb = swl_strb(a);
      st_data = rt_q >> {~a, 3'b000};
    end else if (right_q) begin
      st_strb = swr_strb(a);
      st_data = rt_q << {a, 3'b000};
    end else if (size_q == SZ_BYTE) begin
      st_strb = 4'b0001 << a;
      st_data = {4{rt_q[7:0]}};
    end else if (size_q == SZ_HALF) begin
      st_strb = a[1] ? 4'b1100 : 4'b0011;
      st_data = {2{rt_q[15:0]}};
    end
  end

  mem_load_align u_align (
    .rdata_i  (dm_rdata),
    .rt_i     (rt_q),
    .a_i      (a),
    .size_i   (size_q),
    .unsign_i (unsign_q),
    .left_i   (left_q),
    .right_i  (right_q),
    .result_o (ld_result)
  );

  // A draining access is already dead: hide it from hazard checks.
  assign busy = (state_q == ST_ISSUE) || (state_q == ST_DONE);

  assign dm_req   = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
  assign dm_wr    = store_q;
  assign dm_addr  = {addr_q[31:2], 2'b00};
  assign dm_wstrb = store_q ? st_strb : 4'b0000;
  assign dm_wdata = store_q ? st_data : 32'd0;

  assign mem_to_wb_valid = (state_q == ST_DONE);
  assign mem_wen      = busy && wen_q && !adel_q && !ades_q;
  assign mem_wdest    = busy ? wdest_q : 5'd0;
  assign mem_wdata    = wdata_q;
  assign mem_pc       = pc_q;
  assign mem_adel     = mem_to_wb_valid && adel_q;
  assign mem_ades     = mem_to_wb_valid && ades_q;
  assign mem_badvaddr = addr_q;

endmodule
